burst_ram_arbiter: RTL and testbench

//  Shares one BurstRAM command/data channel between two cache masters (m0 = icache, m1 = dcache).

---
 rtl/burst_ram_arbiter_pkg.sv | 19 +
 rtl/burst_ram_arbiter_rr_arbiter2.sv | 35 +++
 rtl/burst_ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the BurstRAM arbiter: FSM encoding and BurstRAM command codes.
package burst_ram_arbiter_pkg;

   typedef enum logic [4:0] {
      StIdle   = 5'b00001,
      StIssue  = 5'b00010,
      StRdWait = 5'b00100,
      StWrData = 5'b01000,
      StDone   = 5'b10000
   } state_e;

   localparam logic BR_CMD_READ  = 1'b0;
   localparam logic BR_CMD_WRITE = 1'b1;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/burst_ram_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin on ties (or m1-wins when FIXED_PRIORITY), remembers last served.
module rr_arbiter2 #(
   parameter int unsigned FIXED_PRIORITY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic       winner
);

   logic last_served_q, last_served_d;

   always_comb begin
      last_served_d = update ? served : last_served_q;
   end

   always_comb begin
      winner = 1'b0;
      unique case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = (FIXED_PRIORITY != 0) ? 1'b1 : ~last_served_q;
         default: winner = 1'b0;
      endcase
   end

   // Reset to 1 so m0 takes the first tie.
   always_ff @(posedge clk) begin
      if (rst) last_served_q <= 1'b1;
      else     last_served_q <= last_served_d;
   end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM channel between icache (m0) and dcache (m1); grant held for a whole burst.
module burst_ram_arbiter
   import burst_ram_arbiter_pkg::*;
#(
   parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
   parameter int unsigned RAM_BURST_DATA_COUNT    = 4,
   parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
   parameter int unsigned FIXED_PRIORITY          = 0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      m0_req,
   input  logic                                      m0_cmd,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]             m0_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]        m0_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]      m0_data_mask,
   output logic                                      m0_gnt,
   output logic [$clog2(RAM_BURST_DATA_COUNT)-1:0]   m0_wr_beat,
   output logic                                      m0_rd_data_valid,
   output logic                                      m0_done,
   input  logic                                      m1_req,
   input  logic                                      m1_cmd,
   input  logic [RAM_DEPTH_BITWIDTH-1:0]             m1_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]        m1_wr_data,
   input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]      m1_data_mask,
   output logic                                      m1_gnt,
   output logic [$clog2(RAM_BURST_DATA_COUNT)-1:0]   m1_wr_beat,
   output logic                                      m1_rd_data_valid,
   output logic                                      m1_done,
   output logic                                      br_cmd,
   output logic                                      br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]             br_addr,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]        br_wr_data,
   output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]      br_data_mask,
   input  logic                                      br_rd_data_valid,
   input  logic                                      br_busy
);

   localparam int unsigned BeatW = $clog2(RAM_BURST_DATA_COUNT);
   localparam logic [BeatW-1:0] LastBeat = BeatW'(RAM_BURST_DATA_COUNT - 1);

   state_e                        state_q, state_d;
   logic                          owner_q, owner_d;
   logic [1:0]                    gnt_q, gnt_d;
   logic [1:0]                    done_q, done_d;
   logic                          cmd_en_q, cmd_en_d;
   logic                          br_cmd_q, br_cmd_d;
   logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q, br_addr_d;
   logic [BeatW-1:0]              beat_q, beat_d;
   logic                          wr_last_q, wr_last_d;
   logic                          winner;
   logic                          owner_cmd;
   logic [RAM_DEPTH_BITWIDTH-1:0] owner_addr;
   logic                          wr_active;
   logic                          rd_active;

   rr_arbiter2 #(
      .FIXED_PRIORITY (FIXED_PRIORITY)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({m1_req, m0_req}),
      .update (state_q == StDone),
      .served (owner_q),
      .winner (winner)
   );

   assign owner_cmd  = owner_q ? m1_cmd : m0_cmd;
   assign owner_addr = owner_q ? m1_addr : m0_addr;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      done_d    = 2'b00;
      cmd_en_d  = 1'b0;
      br_cmd_d  = BR_CMD_READ;
      br_addr_d = '0;
      beat_d    = beat_q;
      wr_last_d = wr_last_q;
      unique case (state_q)
         StIdle: begin
            if ((m0_req || m1_req) && !br_busy) begin
               owner_d = winner;
               gnt_d   = onehot2(winner);
               state_d = StIssue;
            end
         end
         StIssue: begin
            // Command is registered here and appears one cycle after the grant.
            if (!br_busy) begin
               cmd_en_d  = 1'b1;
               br_cmd_d  = owner_cmd;
               br_addr_d = owner_addr;
               beat_d    = '0;
               wr_last_d = 1'b0;
               state_d   = (owner_cmd == BR_CMD_WRITE) ? StWrData : StRdWait;
            end
         end
         StRdWait: begin
            if (br_rd_data_valid) begin
               if (beat_q == LastBeat) begin
                  beat_d  = '0;
                  gnt_d   = 2'b00;
                  done_d  = gnt_q;
                  state_d = StDone;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StWrData: begin
            if (!wr_last_q) begin
               if (beat_q == LastBeat) wr_last_d = 1'b1;
               else                    beat_d = beat_q + BeatW'(1);
            end else if (!br_busy) begin
               beat_d    = '0;
               wr_last_d = 1'b0;
               gnt_d     = 2'b00;
               done_d    = gnt_q;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         cmd_en_q  <= 1'b0;
         br_cmd_q  <= BR_CMD_READ;
         br_addr_q <= '0;
         beat_q    <= '0;
         wr_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         cmd_en_q  <= cmd_en_d;
         br_cmd_q  <= br_cmd_d;
         br_addr_q <= br_addr_d;
         beat_q    <= beat_d;
         wr_last_q <= wr_last_d;
      end
   end

   // Beat data comes straight from the owner, indexed by the beat we advertise to it.
   assign wr_active = (state_q == StWrData) && !wr_last_q;
   assign rd_active = (state_q == StRdWait);

   assign br_cmd_en    = cmd_en_q;
   assign br_cmd       = br_cmd_q;
   assign br_addr      = br_addr_q;
   assign br_wr_data   = wr_active ? (owner_q ? m1_wr_data : m0_wr_data) : '0;
   assign br_data_mask = wr_active ? (owner_q ? m1_data_mask : m0_data_mask) : '0;

   assign m0_gnt           = gnt_q[0];
   assign m1_gnt           = gnt_q[1];
   assign m0_done          = done_q[0];
   assign m1_done          = done_q[1];
   assign m0_wr_beat       = (wr_active && !owner_q) ? beat_q : '0;
   assign m1_wr_beat       = (wr_active && owner_q) ? beat_q : '0;
   assign m0_rd_data_valid = br_rd_data_valid && rd_active && !owner_q;
   assign m1_rd_data_valid = br_rd_data_valid && rd_active && owner_q;

   assert property (@(posedge clk) disable iff (rst) m0_gnt |-> m0_req);
   assert property (@(posedge clk) disable iff (rst) m1_gnt |-> m1_req);

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter: expected commands/beats queued at stimulus time.
module tb_burst_ram_arbiter;

   typedef struct {
      logic       master;
      logic       cmd;
      logic [3:0] addr;
   } cmd_exp_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  mask;
   } wr_exp_t;

   logic        clk = 1'b0;
   logic        rst, rst_fp;
   logic        m0_req, m0_cmd, m1_req, m1_cmd;
   logic [3:0]  m0_addr, m1_addr;
   logic [63:0] m0_wr_data, m1_wr_data;
   logic [7:0]  m0_data_mask, m1_data_mask;
   logic        m0_gnt, m1_gnt, m0_rd_data_valid, m1_rd_data_valid, m0_done, m1_done;
   logic [1:0]  m0_wr_beat, m1_wr_beat;
   logic        br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
   logic [3:0]  br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;

   logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rdv, fp_m1_rdv, fp_m0_done, fp_m1_done;
   logic [1:0]  fp_m0_wr_beat, fp_m1_wr_beat;
   logic        fp_br_cmd, fp_br_cmd_en;
   logic [3:0]  fp_br_addr;
   logic [63:0] fp_br_wr_data;
   logic [7:0]  fp_br_data_mask;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic        mon_en = 1'b0;
   int          wr_left = 0;
   cmd_exp_t    cmd_q[$];
   wr_exp_t     wr_q[$];

   logic [63:0] wr_pat [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
   logic [7:0]  mask_pat [4] = '{8'h01, 8'h03, 8'hF0, 8'hAA};

   always #5 clk = ~clk;

   assign m1_wr_data   = wr_pat[m1_wr_beat];
   assign m1_data_mask = mask_pat[m1_wr_beat];
   assign m0_wr_data   = 64'hDEAD_0000 + 64'(m0_wr_beat);
   assign m0_data_mask = 8'h5A;

   burst_ram_arbiter #(
      .RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_COUNT(4), .RAM_BURST_DATA_BITWIDTH(64),
      .FIXED_PRIORITY(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_data_mask(m0_data_mask), .m0_gnt(m0_gnt), .m0_wr_beat(m0_wr_beat),
      .m0_rd_data_valid(m0_rd_data_valid), .m0_done(m0_done),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_data_mask(m1_data_mask), .m1_gnt(m1_gnt), .m1_wr_beat(m1_wr_beat),
      .m1_rd_data_valid(m1_rd_data_valid), .m1_done(m1_done),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
   );

   // Fixed-priority variant, held in reset except while its tie-break is examined.
   burst_ram_arbiter #(
      .RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_COUNT(4), .RAM_BURST_DATA_BITWIDTH(64),
      .FIXED_PRIORITY(1)
   ) u_dut_fp (
      .clk(clk), .rst(rst_fp),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_data_mask(m0_data_mask), .m0_gnt(fp_m0_gnt), .m0_wr_beat(fp_m0_wr_beat),
      .m0_rd_data_valid(fp_m0_rdv), .m0_done(fp_m0_done),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_data_mask(m1_data_mask), .m1_gnt(fp_m1_gnt), .m1_wr_beat(fp_m1_wr_beat),
      .m1_rd_data_valid(fp_m1_rdv), .m1_done(fp_m1_done),
      .br_cmd(fp_br_cmd), .br_cmd_en(fp_br_cmd_en), .br_addr(fp_br_addr),
      .br_wr_data(fp_br_wr_data), .br_data_mask(fp_br_data_mask),
      .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic master, input logic cmd, input logic [3:0] addr);
      cmd_exp_t e;
      e.master = master;
      e.cmd    = cmd;
      e.addr   = addr;
      cmd_q.push_back(e);
   endtask

   task automatic wait_cmd(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (br_cmd_en) return;
      end
      check_eq("cmd_timeout", {63'd0, br_cmd_en}, 64'd1);
   endtask

   // RAM returns four consecutive strobes; checks steering and the done pulse.
   task automatic read_rest(input logic owner, input logic drop);
      for (int b = 0; b < 4; b++) begin
         tick();
         br_rd_data_valid = 1'b1;
         #1;
         check_eq("rd_fwd_m0", {63'd0, m0_rd_data_valid}, {63'd0, !owner});
         check_eq("rd_fwd_m1", {63'd0, m1_rd_data_valid}, {63'd0, owner});
      end
      tick();
      br_rd_data_valid = 1'b0;
      check_eq("rd_done_owner", {63'd0, owner ? m1_done : m0_done}, 64'd1);
      check_eq("rd_done_other", {63'd0, owner ? m0_done : m1_done}, 64'd0);
      check_eq("rd_gnt_released", {62'd0, m1_gnt, m0_gnt}, 64'd0);
      if (drop) begin
         if (owner) m1_req = 1'b0;
         else       m0_req = 1'b0;
      end
      tick();
      check_eq("rd_done_one_cycle", {62'd0, m1_done, m0_done}, 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         wr_left = 0;
      end else if (mon_en) begin
         if (br_cmd_en) begin
            check_eq("cmd_while_busy", {63'd0, br_busy}, 64'd0);
            check_eq("cmd_expected", {63'd0, cmd_q.size() != 0}, 64'd1);
            if (cmd_q.size() != 0) begin
               cmd_exp_t e;
               e = cmd_q.pop_front();
               check_eq("cmd_owner", {62'd0, m1_gnt, m0_gnt}, e.master ? 64'd2 : 64'd1);
               check_eq("cmd_addr", {60'd0, br_addr}, {60'd0, e.addr});
               check_eq("cmd_kind", {63'd0, br_cmd}, {63'd0, e.cmd});
               if (e.cmd) wr_left = 4;
            end
         end
         if (wr_left > 0) begin
            wr_exp_t w;
            check_eq("wr_expected", {63'd0, wr_q.size() != 0}, 64'd1);
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               check_eq("wr_data", br_wr_data, w.data);
               check_eq("wr_mask", {56'd0, br_data_mask}, {56'd0, w.mask});
            end
            wr_left--;
         end
         if (!m0_gnt && !m1_gnt)
            check_eq("br_idle_zero", {br_cmd_en, br_cmd, br_addr, br_data_mask, |br_wr_data},
                     64'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      wr_exp_t w;
      rst = 1'b1; rst_fp = 1'b1;
      m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0;
      m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0;
      br_rd_data_valid = 1'b0; br_busy = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
      check_eq("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
      check_eq("rst_done", {62'd0, m1_done, m0_done}, 64'd0);
      check_eq("rst_cmd_en", {63'd0, br_cmd_en}, 64'd0);

      // 1: lone m0 read, address 5
      m0_cmd = 1'b0; m0_addr = 4'd5; m0_req = 1'b1;
      push_cmd(1'b0, 1'b0, 4'd5);
      tick();
      check_eq("t1_gnt_at_1", {62'd0, m1_gnt, m0_gnt}, 64'd1);
      check_eq("t1_no_cmd_at_1", {63'd0, br_cmd_en}, 64'd0);
      wait_cmd(n);
      check_eq("t1_cmd_at_2", n, 64'd1);
      read_rest(1'b0, 1'b1);

      // 2: simultaneous requests after reset, both masters keep re-requesting
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0; rst_fp = 1'b0;
      tick();
      m0_addr = 4'hA; m1_addr = 4'hB; m0_cmd = 1'b0; m1_cmd = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1;
      push_cmd(1'b0, 1'b0, 4'hA);
      push_cmd(1'b1, 1'b0, 4'hB);
      push_cmd(1'b0, 1'b0, 4'hA);
      push_cmd(1'b1, 1'b0, 4'hB);
      tick();
      check_eq("t2_rr_first_m0", {62'd0, m1_gnt, m0_gnt}, 64'd1);
      check_eq("t2_fp_first_m1", {62'd0, fp_m1_gnt, fp_m0_gnt}, 64'd2);
      rst_fp = 1'b1;
      wait_cmd(n); read_rest(1'b0, 1'b0);
      wait_cmd(n); read_rest(1'b1, 1'b0);
      wait_cmd(n); read_rest(1'b0, 1'b1);
      wait_cmd(n); read_rest(1'b1, 1'b1);

      // 3: m1 write, RAM busy for a while after the command
      m1_cmd = 1'b1; m1_addr = 4'd7; m1_req = 1'b1;
      push_cmd(1'b1, 1'b1, 4'd7);
      for (int b = 0; b < 4; b++) begin
         w.data = wr_pat[b];
         w.mask = mask_pat[b];
         wr_q.push_back(w);
      end
      wait_cmd(n);
      tick();
      br_busy = 1'b1;
      repeat (5) begin
         tick();
         check_eq("t3_no_done_while_busy", {63'd0, m1_done}, 64'd0);
      end
      br_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (m1_done) break;
      end
      check_eq("t3_done", {63'd0, m1_done}, 64'd1);
      m1_req = 1'b0; m1_cmd = 1'b0;
      tick();
      check_eq("t3_done_one_cycle", {63'd0, m1_done}, 64'd0);

      // 4: busy holds off a pending request
      br_busy = 1'b1;
      m0_cmd = 1'b0; m0_addr = 4'd9; m0_req = 1'b1;
      push_cmd(1'b0, 1'b0, 4'd9);
      repeat (10) begin
         tick();
         check_eq("t4_no_cmd_busy", {63'd0, br_cmd_en}, 64'd0);
      end
      br_busy = 1'b0;
      wait_cmd(n);
      check_eq("t4_cmd_after_busy", {63'd0, br_cmd_en}, 64'd1);
      read_rest(1'b0, 1'b1);

      // 5: reset during read beat 2, then a stray strobe
      m0_addr = 4'd3; m0_req = 1'b1;
      push_cmd(1'b0, 1'b0, 4'd3);
      wait_cmd(n);
      tick(); br_rd_data_valid = 1'b1;
      tick();
      tick(); rst = 1'b1;
      tick();
      br_rd_data_valid = 1'b0;
      #1;
      check_eq("t5_rst_ctl", {m0_gnt, m1_gnt, m0_done, m1_done, m0_wr_beat, m1_wr_beat,
                              m0_rd_data_valid, m1_rd_data_valid, br_cmd_en, br_cmd, br_addr},
               64'd0);
      check_eq("t5_rst_wdata", br_wr_data, 64'd0);
      check_eq("t5_rst_mask", {56'd0, br_data_mask}, 64'd0);
      rst = 1'b0; m0_req = 1'b0;
      tick();
      br_rd_data_valid = 1'b1;
      #1;
      check_eq("t5_stray_dropped", {62'd0, m1_rd_data_valid, m0_rd_data_valid}, 64'd0);
      tick();
      br_rd_data_valid = 1'b0;
      check_eq("t5_idle_after", {61'd0, br_cmd_en, m1_gnt, m0_gnt}, 64'd0);

      // 6: m0 back-to-back while m1 waits; m1 must slot in between
      m0_addr = 4'd1; m0_req = 1'b1;
      push_cmd(1'b0, 1'b0, 4'd1);
      tick();
      m1_addr = 4'd2; m1_cmd = 1'b0; m1_req = 1'b1;
      push_cmd(1'b1, 1'b0, 4'd2);
      push_cmd(1'b0, 1'b0, 4'd1);
      wait_cmd(n); read_rest(1'b0, 1'b0);
      wait_cmd(n); read_rest(1'b1, 1'b1);
      wait_cmd(n); read_rest(1'b0, 1'b1);

      repeat (3) tick();
      check_eq("sb_cmd_empty", cmd_q.size(), 64'd0);
      check_eq("sb_wr_empty", wr_q.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
